// File: rtl/chip_loader_pkg.sv
// Shared state type, memory-field widths and address packing for the chip loader.
package chip_loader_pkg;

   typedef enum logic [2:0] {IDLE, KERNEL, INPUT, OVERLAP, READY} state_t;

   localparam int TILE_WIDTH    = 64;
   localparam int TILE_HEIGHT   = 128;
   localparam int TILE_CHANNELS = 2;
   localparam int OUT_CHANNELS  = 16;
   localparam int KERNEL_SIZE   = 3;

   localparam int X_W     = 6;
   localparam int Y_W     = 7;
   localparam int CH_W    = 1;
   localparam int KY_W    = 2;
   localparam int KX_W    = 2;
   localparam int OUTCH_W = 4;

   localparam int KSEL_BIT = 15;

   // Every counter level is wide enough for the largest field (y).
   localparam int CNT_W      = 7;
   localparam int CNT_LEVELS = 4;
   typedef logic [CNT_W-1:0] cnt_t;

   function automatic logic [15:0] kernel_addr(cnt_t inch, cnt_t ky, cnt_t kx, cnt_t outch);
      logic [15:0] a;
      a = {7'b0, inch[CH_W-1:0], ky[KY_W-1:0], kx[KX_W-1:0], outch[OUTCH_W-1:0]};
      a[KSEL_BIT] = 1'b1;
      return a;
   endfunction

   function automatic logic [15:0] input_addr(cnt_t inch, cnt_t y, cnt_t x);
      return {2'b00, inch[CH_W-1:0], y[Y_W-1:0], x[X_W-1:0]};
   endfunction

   function automatic logic [15:0] overlap_addr(cnt_t inch, cnt_t y);
      return {8'b0, inch[CH_W-1:0], y[Y_W-1:0]};
   endfunction

endpackage

// File: rtl/chip_loader_counter.sv
// Chain of wrap counters: level 0 is innermost, each level steps when all lower levels wrap.
module nested_counter
   import chip_loader_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear,
   input  logic                                inc,
   input  logic [CNT_LEVELS-1:0][CNT_W-1:0]    limits,
   output logic [CNT_LEVELS-1:0][CNT_W-1:0]    values,
   output logic                                last
);

   logic [CNT_LEVELS-1:0] at_lim;
   logic [CNT_LEVELS-1:0] step;

   always_comb begin
      logic carry;
      carry = inc;
      at_lim = '0;
      step = '0;
      for (int i = 0; i < CNT_LEVELS; i++) begin
         at_lim[i] = (values[i] == limits[i]);
         step[i] = carry;
         carry = carry & at_lim[i];
      end
   end

   assign last = &at_lim;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         values <= '0;
      end else if (clear) begin
         values <= '0;
      end else begin
         for (int i = 0; i < CNT_LEVELS; i++) begin
            if (step[i]) values[i] <= at_lim[i] ? '0 : values[i] + cnt_t'(1);
         end
      end
   end

endmodule

// File: rtl/chip_loader.sv
// Streams one tile (kernel, input map, overlap columns) into the chip memories via the A/B load port.
module chip_loader
   import chip_loader_pkg::*;
#(
   parameter int IO_DATA_WIDTH = 16
)(
   input  logic                     clk,
   input  logic                     arst_n_in,
   input  logic                     start,
   input  logic [7:0]               fm_height,
   input  logic                     fsm_done,
   input  logic [IO_DATA_WIDTH-1:0] src_data,
   input  logic                     src_valid,
   output logic                     src_ready,
   output logic [IO_DATA_WIDTH-1:0] a_input,
   output logic [IO_DATA_WIDTH-1:0] b_input,
   output logic                     a_valid,
   output logic                     b_valid,
   output logic                     int_mem_we,
   output logic                     overlap_cache_we,
   output logic                     b_zero,
   output logic                     data_ready,
   output logic                     busy
);

   state_t state, next_state;
   logic [7:0] height;
   logic [CNT_LEVELS-1:0][CNT_W-1:0] limits, values;
   logic cnt_last, row_valid, in_load, zero_fill, write, clear;
   logic [15:0] addr;

   nested_counter u_cnt (
      .clk    (clk),
      .rst_n  (arst_n_in),
      .clear  (clear),
      .inc    (write),
      .limits (limits),
      .values (values),
      .last   (cnt_last)
   );

   // Per-phase counter layout, address packing and valid-row test.
   always_comb begin
      limits = '0;
      row_valid = 1'b0;
      addr = '0;
      case (state)
         KERNEL: begin
            limits = {cnt_t'(TILE_CHANNELS-1), cnt_t'(KERNEL_SIZE-1),
                      cnt_t'(KERNEL_SIZE-1), cnt_t'(OUT_CHANNELS-1)};
            row_valid = 1'b1;
            addr = kernel_addr(values[3], values[2], values[1], values[0]);
         end
         INPUT: begin
            limits = {cnt_t'(0), cnt_t'(TILE_CHANNELS-1),
                      cnt_t'(TILE_HEIGHT-1), cnt_t'(TILE_WIDTH-1)};
            row_valid = ({1'b0, values[1]} < height);
            addr = input_addr(values[2], values[1], values[0]);
         end
         OVERLAP: begin
            limits = {cnt_t'(0), cnt_t'(0), cnt_t'(TILE_CHANNELS-1), cnt_t'(TILE_HEIGHT-1)};
            row_valid = ({1'b0, values[0]} < height);
            addr = overlap_addr(values[1], values[0]);
         end
         default: ;
      endcase
   end

   always_comb begin
      next_state = state;
      in_load = (state == KERNEL) || (state == INPUT) || (state == OVERLAP);
      src_ready = in_load && row_valid;
      zero_fill = in_load && !row_valid;
      write = (src_valid && src_ready) || zero_fill;
      clear = (state == IDLE);
      case (state)
         IDLE:    if (start) next_state = KERNEL;
         KERNEL:  if (write && cnt_last) next_state = INPUT;
         INPUT:   if (write && cnt_last) next_state = OVERLAP;
         OVERLAP: if (write && cnt_last) next_state = READY;
         READY:   if (fsm_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state <= IDLE;
         height <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && start)
            height <= (fm_height > 8'(TILE_HEIGHT)) ? 8'(TILE_HEIGHT) : fm_height;
      end
   end

   // Write port is one register stage behind the issuing cycle.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         a_input <= '0;
         b_input <= '0;
         int_mem_we <= 1'b0;
         overlap_cache_we <= 1'b0;
         b_zero <= 1'b0;
      end else begin
         int_mem_we <= write && (state == KERNEL || state == INPUT);
         overlap_cache_we <= write && (state == OVERLAP);
         b_zero <= zero_fill && (state == INPUT);
         if (write) begin
            a_input <= IO_DATA_WIDTH'(addr);
            b_input <= row_valid ? src_data : '0;
         end
      end
   end

   assign a_valid = int_mem_we | overlap_cache_we;
   assign b_valid = int_mem_we | overlap_cache_we;
   assign busy = (state != IDLE);
   assign data_ready = (state == READY);

endmodule

// File: tb/tb_chip_loader.sv
// Self-checking bench for chip_loader against a per-write table built from the load rules.
module tb_chip_loader;

   localparam int NW = 288 + 16384 + 256;
   localparam int BUDGET = 60000;

   logic clk = 1'b0;
   logic arst_n_in = 1'b0;
   logic start = 1'b0;
   logic [7:0] fm_height = 8'd0;
   logic fsm_done = 1'b0;
   logic [15:0] src_data = 16'd0;
   logic src_valid = 1'b0;
   logic src_ready;
   logic [15:0] a_input, b_input;
   logic a_valid, b_valid, int_mem_we, overlap_cache_we, b_zero, data_ready, busy;

   chip_loader #(.IO_DATA_WIDTH(16)) dut (
      .clk              (clk),
      .arst_n_in        (arst_n_in),
      .start            (start),
      .fm_height        (fm_height),
      .fsm_done         (fsm_done),
      .src_data         (src_data),
      .src_valid        (src_valid),
      .src_ready        (src_ready),
      .a_input          (a_input),
      .b_input          (b_input),
      .a_valid          (a_valid),
      .b_valid          (b_valid),
      .int_mem_we       (int_mem_we),
      .overlap_cache_we (overlap_cache_we),
      .b_zero           (b_zero),
      .data_ready       (data_ready),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   wire [41:0] outs = {a_input, b_input, a_valid, b_valid, int_mem_we, overlap_cache_we,
                       b_zero, data_ready, busy, src_ready, 2'b00};

   int compared = 0;
   int mismatched = 0;

   // Expected write table: address, consumes-a-word, memory (1 int, 2 overlap), zero flag.
   logic [15:0] e_addr [NW];
   bit          e_cons [NW];
   int          e_kind [NW];
   bit          e_zero [NW];
   logic [15:0] words  [NW];

   logic [15:0] o_addr [NW];
   logic [15:0] o_data [NW];
   bit          o_zero [NW];
   int n_obs, n_we, n_ov, n_zero, err_cyc, first_err, first_code;
   bit ready_at_last;

   task automatic build_model(input int h);
      int hc, n;
      hc = (h > 128) ? 128 : h;
      n = 0;
      for (int k = 0; k < 288; k++) begin
         e_addr[n] = 16'(32768 + (k / 144) * 256 + ((k / 48) % 3) * 64 + ((k / 16) % 3) * 16 + k % 16);
         e_cons[n] = 1'b1; e_kind[n] = 1; e_zero[n] = 1'b0; n++;
      end
      for (int i = 0; i < 16384; i++) begin
         e_addr[n] = 16'(i);
         e_cons[n] = ((i / 64) % 128) < hc;
         e_kind[n] = 1; e_zero[n] = !e_cons[n]; n++;
      end
      for (int j = 0; j < 256; j++) begin
         e_addr[n] = 16'(j);
         e_cons[n] = (j % 128) < hc;
         e_kind[n] = 2; e_zero[n] = 1'b0; n++;
      end
   endtask

   task automatic note_err(input int cyc, input int code);
      err_cyc++;
      if (first_err < 0) begin
         first_err = cyc;
         first_code = code;
      end
   endtask

   // Runs one full load; mode 0 = always valid, 1 = valid toggles, 2 = random valid.
   task automatic run_load(input int h, input int mode);
      int k, cons, pk, cyc;
      bit pend;
      logic [15:0] pdata;
      logic [1:0] exp_we;
      build_model(h);
      for (int i = 0; i < NW; i++) words[i] = 16'($urandom);
      err_cyc = 0; first_err = -1; first_code = 0;
      n_obs = 0; n_we = 0; n_ov = 0; n_zero = 0; ready_at_last = 1'b0;
      @(negedge clk);
      fm_height = 8'(h); start = 1'b1; src_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      k = 0; cons = 0; pk = 0; pend = 1'b0; pdata = 16'h0; cyc = 0;
      while (cyc < BUDGET) begin
         exp_we = pend ? ((e_kind[pk] == 1) ? 2'b10 : 2'b01) : 2'b00;
         n_we += int'(int_mem_we);
         n_ov += int'(overlap_cache_we);
         if ({int_mem_we, overlap_cache_we} !== exp_we) note_err(cyc, 1);
         if (a_valid !== (int_mem_we | overlap_cache_we) || b_valid !== a_valid) note_err(cyc, 2);
         if (pend) begin
            if (a_input !== e_addr[pk]) note_err(cyc, 3);
            if (b_input !== pdata) note_err(cyc, 4);
            if (b_zero !== e_zero[pk]) note_err(cyc, 5);
            o_addr[n_obs] = a_input;
            o_data[n_obs] = b_input;
            o_zero[n_obs] = b_zero;
            n_zero += int'(b_zero === 1'b1);
            n_obs++;
            if (pk == NW - 1) ready_at_last = (data_ready === 1'b1);
         end else if (b_zero !== 1'b0) note_err(cyc, 5);
         if (src_ready !== (k < NW && e_cons[k])) note_err(cyc, 6);
         if (busy !== 1'b1 || data_ready !== (k == NW)) note_err(cyc, 7);
         if (k == NW && !pend) break;
         case (mode)
            0: src_valid = 1'b1;
            1: src_valid = (cyc % 2 == 0);
            default: src_valid = ($urandom % 8) != 0;
         endcase
         src_data = words[(cons < NW) ? cons : 0];
         pend = (k < NW) && (!e_cons[k] || src_valid);
         if (pend) begin
            pk = k;
            pdata = e_cons[k] ? words[cons] : 16'h0;
            if (e_cons[k]) cons++;
            k++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      src_valid = 1'b0;
      if (k != NW || cyc >= BUDGET) note_err(cyc, 8);
   endtask

   task automatic check_cycle_model(input string name);
      compared++;
      if (err_cyc !== 0) begin
         mismatched++;
         $display("FAIL %s: %0d cycle errors, first at cycle %0d (check %0d), required 0",
                  name, err_cyc, first_err, first_code);
      end
   endtask

   task automatic finish_load(input string name);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      compared++;
      if ({data_ready, busy} !== 2'b11) begin
         mismatched++;
         $display("FAIL %s_start_in_ready: data_ready,busy=%b required 11", name, {data_ready, busy});
      end
      fsm_done = 1'b1;
      @(negedge clk); fsm_done = 1'b0;
      compared++;
      if ({data_ready, busy} !== 2'b00) begin
         mismatched++;
         $display("FAIL %s_fsm_done: data_ready,busy=%b required 00", name, {data_ready, busy});
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      compared++;
      if (outs !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: outs=%h required 0", outs);
      end
      arst_n_in = 1'b1;
      @(negedge clk); fsm_done = 1'b1;
      @(negedge clk); fsm_done = 1'b0;
      @(negedge clk);
      compared++;
      if (outs !== '0) begin
         mismatched++;
         $display("FAIL idle_fsm_done: outs=%h required 0", outs);
      end
   endtask

   task automatic test_full_height();
      logic [15:0] exp_a [6];
      int idx [6];
      run_load(128, 0);
      check_cycle_model("full_cycle_model");
      idx = '{0, 16, 48, 287, 288, 288 + 16383};
      exp_a = '{16'h8000, 16'h8010, 16'h8040, 16'h81AF, 16'h0000, 16'h3FFF};
      for (int i = 0; i < 6; i++) begin
         compared++;
         if (o_addr[idx[i]] !== exp_a[i]) begin
            mismatched++;
            $display("FAIL full_addr_w%0d: a_input=%h required %h", idx[i], o_addr[idx[i]], exp_a[i]);
         end
      end
      compared++;
      if (o_data[0] !== words[0] || o_data[287] !== words[287]) begin
         mismatched++;
         $display("FAIL full_kernel_data: got %h/%h required %h/%h", o_data[0], o_data[287], words[0], words[287]);
      end
      compared++;
      if (n_zero !== 0) begin
         mismatched++;
         $display("FAIL full_b_zero: count=%0d required 0", n_zero);
      end
      compared++;
      if (n_we !== 288 + 16384 || n_ov !== 256) begin
         mismatched++;
         $display("FAIL full_strobe_counts: we=%0d ov=%0d required %0d/256", n_we, n_ov, 288 + 16384);
      end
      compared++;
      if (o_addr[NW-1] !== 16'h00FF || !ready_at_last) begin
         mismatched++;
         $display("FAIL full_last_overlap: a_input=%h ready=%0d required 00ff/1", o_addr[NW-1], ready_at_last);
      end
      finish_load("full");
   endtask

   task automatic test_height_100();
      int fz, run, nz;
      logic [15:0] fa;
      run_load(100, 2);
      check_cycle_model("h100_cycle_model");
      fz = -1; run = 0; nz = 0;
      for (int i = 0; i < n_obs; i++) if (o_zero[i] && fz < 0) fz = i;
      if (fz >= 0) for (int i = fz; i < n_obs && o_zero[i]; i++) run++;
      fa = (fz >= 0) ? o_addr[fz] : 16'hFFFF;
      compared++;
      if (fa !== 16'h1900 || run !== 1792) begin
         mismatched++;
         $display("FAIL h100_zero_run: start=%h len=%0d required 1900/1792", fa, run);
      end
      compared++;
      if (o_addr[288 + 8192] !== 16'h2000 || o_zero[288 + 8192] !== 1'b0 || o_zero[288 + 8191] !== 1'b1) begin
         mismatched++;
         $display("FAIL h100_inch1_restart: a_input=%h zero=%0d prev_zero=%0d required 2000/0/1",
                  o_addr[288 + 8192], o_zero[288 + 8192], o_zero[288 + 8191]);
      end
      compared++;
      if (n_zero !== 3584) begin
         mismatched++;
         $display("FAIL h100_zero_count: count=%0d required 3584", n_zero);
      end
      for (int i = 288 + 16384 + 100; i < 288 + 16384 + 128; i++) if (o_data[i] !== 16'h0) nz++;
      compared++;
      if (nz !== 0) begin
         mismatched++;
         $display("FAIL h100_overlap_pad: nonzero words=%0d required 0", nz);
      end
      finish_load("h100");
   endtask

   task automatic test_backpressure();
      int bad;
      run_load(8, 1);
      check_cycle_model("bp_cycle_model");
      bad = 0;
      for (int i = 0; i < NW; i++) if (o_addr[i] !== e_addr[i]) bad++;
      compared++;
      if (n_obs !== NW || bad !== 0) begin
         mismatched++;
         $display("FAIL bp_addr_sequence: strobes=%0d wrong=%0d required %0d/0", n_obs, bad, NW);
      end
      finish_load("bp");
   endtask

   task automatic test_clamp();
      run_load(200, 0);
      check_cycle_model("clamp_cycle_model");
      compared++;
      if (n_zero !== 0) begin
         mismatched++;
         $display("FAIL clamp_b_zero: count=%0d required 0", n_zero);
      end
      finish_load("clamp");
   endtask

   task automatic test_abort();
      @(negedge clk); fm_height = 8'd64; start = 1'b1;
      @(negedge clk); start = 1'b0; src_valid = 1'b1;
      repeat (1000) begin
         @(negedge clk);
         src_data = 16'($urandom);
      end
      compared++;
      if ({busy, int_mem_we, a_input[15]} !== 3'b110) begin
         mismatched++;
         $display("FAIL abort_mid_input: busy,we,a15=%b required 110", {busy, int_mem_we, a_input[15]});
      end
      #2 arst_n_in = 1'b0;
      #1;
      compared++;
      if (outs !== '0) begin
         mismatched++;
         $display("FAIL abort_outputs: outs=%h required 0", outs);
      end
      @(negedge clk); arst_n_in = 1'b1; src_valid = 1'b0;
      @(negedge clk); fm_height = 8'd128; start = 1'b1;
      @(negedge clk); start = 1'b0; src_valid = 1'b1; src_data = 16'h1234;
      @(negedge clk); src_valid = 1'b0;
      compared++;
      if ({int_mem_we, a_input, b_input} !== {1'b1, 16'h8000, 16'h1234}) begin
         mismatched++;
         $display("FAIL abort_restart: we=%0d a=%h b=%h required 1/8000/1234", int_mem_we, a_input, b_input);
      end
      arst_n_in = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_height();
      test_height_100();
      test_backpressure();
      test_clamp();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/chip_loader.md
# chip_loader

Host-side transmitter that streams one tile of kernel weights, input feature map and overlap-column data into the accelerator chip's on-chip memories, using the chip's address/data load protocol. It consumes a flat word stream, generates the packed memory addresses, drives the write strobes and zero-padding flag, then raises `data_ready` and holds it until the chip reports `fsm_done`.

## Interface
- `IO_DATA_WIDTH`, 16: word width of stream, `a_input` and `b_input`.
- `TILE_WIDTH`, 64: columns per tile (6-bit x field).
- `TILE_HEIGHT`, 128: rows per tile (7-bit y field).
- `TILE_CHANNELS`, 2: input channels per tile (1-bit field).
- `OUT_CHANNELS`, 16: output channels in the kernel memory (4-bit field).
- `KERNEL_SIZE`, 3: kernel side (2-bit ky/kx fields).

Ports:
- `clk` in 1: clock.
- `arst_n_in` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a load. Sampled only in IDLE.
- `fm_height` in 8: valid rows of this tile. Sampled with `start`. Values above 128 clamp to 128.
- `fsm_done` in 1: chip computation finished.
- `src_data` in 16, `src_valid` in 1, `src_ready` out 1: source word stream.
- `a_input` out 16: write address word.
- `b_input` out 16: write data word.
- `a_valid`, `b_valid` out 1: both equal the write strobe.
- `int_mem_we` out 1: input/kernel memory write.
- `overlap_cache_we` out 1: overlap cache write.
- `b_zero` out 1: write zero instead of `b_input`.
- `data_ready` out 1: tile fully loaded.
- `busy` out 1: state is not IDLE.

## Operation
- States are IDLE, KERNEL, INPUT, OVERLAP and READY.
- IDLE moves to KERNEL on `start`. A `start` in any other state is ignored.
- KERNEL: nested counters, innermost first: outch 0..15, kx 0..2, ky 0..2, inch 0..1. That gives 288 words.
  - `a_input` = {1, 6'b0, inch, ky[1:0], kx[1:0], outch[3:0]}.
  - Strobe: `int_mem_we`.
- INPUT: counters x 0..63 (innermost), y 0..127, inch 0..1. That gives 16384 writes.
  - `a_input` = {2'b00, inch, y[6:0], x[5:0]}.
  - Rows with y < H (H = clamped `fm_height`): consume a source word and write it.
  - Rows with y ≥ H: `src_ready`=0, one write per cycle with `b_zero`=1 and `b_input`=0.
- OVERLAP: counters y 0..127 (innermost), inch 0..1. That gives 256 writes.
  - `a_input` = {8'b0, inch, y[6:0]}.
  - Strobe: `overlap_cache_we`.
  - Rows with y ≥ H are written with `b_input`=0, consume nothing, and keep `b_zero`=0.
- READY: `data_ready`=1. `fsm_done` returns the block to IDLE. In any other state `fsm_done` is ignored.
- `src_ready` is 1 only in KERNEL, in OVERLAP rows y < H, and in INPUT rows y < H.
- Counters advance only when a write is issued: either a handshake (`src_valid`&&`src_ready`) or a zero-fill cycle.
- Reset mid-operation: return to IDLE and drive every output to 0. Partial memory contents are not erased.

## Timing
- Reset values: every output is 0.
- `start` in cycle t: state becomes KERNEL in t+1, and `busy` and `src_ready` are 1 from t+1.
- Write outputs are registered with 1-cycle latency. A write issued in cycle n presents `a_input`/`b_input`/strobe in cycle n+1 for exactly one cycle. With no new write, the strobes fall to 0.
- `src_ready` is combinational from state and counters. It does not depend on `src_valid`.
- Last KERNEL write moves to INPUT in the next cycle with no bubble. The same holds for INPUT to OVERLAP.
- `data_ready` rises in the same cycle the last overlap strobe is presented.
- `fsm_done` in READY in cycle r: `data_ready`=0 and `busy`=0 in r+1.
- Minimum load time with an always-valid source is 16928 cycles from `start`+1 to the last strobe.

## Structure
- Shared package `chip_loader_pkg` holds:
  - the state enum;
  - field-width localparams (X 6, Y 7, CH 1, KY/KX 2, OUTCH 4);
  - the kernel-select bit position 15;
  - address-pack functions `kernel_addr`, `input_addr` and `overlap_addr`.
- One sub-module, `nested_counter`: parameterised chain of wrap counters with `inc`, per-level limits, per-level values and a `last` flag. Instantiated once, with limits reloaded per state.

## Test plan
- Reset, then idle: all outputs 0. A `fsm_done` pulse in IDLE causes no change.
- Kernel addresses, always-valid source:
  - word 0 → `a_input`=0x8000;
  - word 16 → 0x8010;
  - word 48 → 0x8040;
  - word 287 → 0x81AF;
  - `b_input` equals the consumed data each time.
- Full-height input (`fm_height`=128):
  - first input strobe `a_input`=0x0000;
  - last input strobe 0x3FFF;
  - `b_zero` is never 1;
  - exactly 16384 `int_mem_we` pulses.
- `fm_height`=100:
  - at address 0x1900 (inch 0, y 100), `src_ready`=0 and `b_zero`=1 for 1792 consecutive strobes;
  - inch 1 restarts consumption at 0x2000;
  - overlap addresses 0x64..0x7F carry `b_input`=0.
- Backpressure: `src_valid` toggled 1/0 every cycle. Strobes appear only after handshake cycles, counters hold during gaps, and the address sequence is unchanged.
- End and abort:
  - `data_ready`=1 after the last overlap strobe at address 0xFF;
  - `fsm_done` clears `data_ready` and `busy` next cycle;
  - `arst_n_in` low during INPUT zeroes all outputs immediately;
  - a new `start` restarts at 0x8000.
